fir_mac_seq: RTL

Time-multiplexed FIR/MAC stage directly downstream of the data_delay tap line.
- On request, snapshots all DELAY taps and a coefficient set, then computes y = sum(tap[k]*coef[k]) with one multiplier over TAPS cycles.
- Returns the full-precision result with a one-cycle valid pulse.
- Feeds the filter-output / decimation logic that follows.

---
 rtl/dsp_pkg.sv | 17 +
 rtl/fir_mac_seq_if.sv | 42 ++++
 rtl/fir_mac_seq_mac_unit.sv | 25 ++
 rtl/fir_mac_seq.sv | 94 +++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared DSP package.
// Holds the two-state FSM encoding used by the sequential filter stages and
// the helper that sizes a MAC accumulator.
package dsp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_state_t;

    // Accumulator width that can hold the sum of 'taps' full-precision
    // products without overflow, including the all-minimum corner.
    function automatic int acc_width(input int bits, input int cbits, input int taps);
        return bits + cbits + $clog2(taps);
    endfunction

endpackage

// File: rtl/fir_mac_seq_if.sv
// Bus between the FIR/MAC stage and its controller.
//   i_taps    flattened tap vector, tap k at [k*BITS +: BITS], k=0 newest
//   i_coef    flattened coefficients, coef k at [k*CBITS +: CBITS]
//   i_start   start request
//   o_busy    computation in progress
//   o_valid   one-cycle pulse when o_y is updated
//   o_y       signed result, held until the next result
//   dbg_state current FSM state
//
// Handshake: i_start is a request that is only taken while the stage is IDLE;
// a request seen while busy is dropped, not queued. Taking a request snapshots
// i_taps/i_coef at that same edge. o_valid is a single-cycle pulse with no
// back-pressure: the consumer must capture o_y in that cycle (o_y also holds
// afterwards). A new request may be issued in the o_valid cycle itself.
interface fir_mac_seq_if
    import dsp_pkg::*;
#(
    parameter int TAPS  = 4,
    parameter int BITS  = 16,
    parameter int CBITS = 16,
    parameter int ACCW  = acc_width(BITS, CBITS, TAPS)
) ();

    logic [TAPS*BITS-1:0]  i_taps;
    logic [TAPS*CBITS-1:0] i_coef;
    logic                  i_start;
    logic                  o_busy;
    logic                  o_valid;
    logic signed [ACCW-1:0] o_y;
    fsm_state_t            dbg_state;

    modport master (
        output i_taps, i_coef, i_start,
        input  o_busy, o_valid, o_y, dbg_state
    );

    modport slave (
        input  i_taps, i_coef, i_start,
        output o_busy, o_valid, o_y, dbg_state
    );

endinterface

// File: rtl/fir_mac_seq_mac_unit.sv
// mac_unit: combinational signed multiply-accumulate step.
//   i_tap    signed sample
//   i_coef   signed coefficient
//   i_acc    running accumulator
//   o_acc    i_acc + sign-extended i_tap*i_coef
module mac_unit #(
    parameter int BITS  = 16,
    parameter int CBITS = 16,
    parameter int ACCW  = 34
) (
    input  logic signed [BITS-1:0]  i_tap,
    input  logic signed [CBITS-1:0] i_coef,
    input  logic signed [ACCW-1:0]  i_acc,
    output logic signed [ACCW-1:0]  o_acc
);

    logic signed [BITS+CBITS-1:0] prod;
    logic signed [ACCW-1:0]       prod_ext;

    assign prod     = i_tap * i_coef;
    // Size cast of a signed operand sign-extends.
    assign prod_ext = ACCW'(prod);
    assign o_acc    = i_acc + prod_ext;

endmodule

// File: rtl/fir_mac_seq.sv
// fir_mac_seq: time-multiplexed FIR/MAC stage.
// On a start request it snapshots all taps and coefficients, then computes
// y = sum(tap[k]*coef[k]) using one multiplier over TAPS cycles and presents
// the full-precision result with a one-cycle o_valid pulse.
//   i_clk  clock, rising edge
//   i_rst  synchronous reset, active-low
//   bus    fir_mac_seq_if slave (taps, coefs, start, busy, valid, y, state)
module fir_mac_seq
    import dsp_pkg::*;
#(
    parameter int TAPS  = 4,
    parameter int BITS  = 16,
    parameter int CBITS = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    fir_mac_seq_if.slave  bus
);

    localparam int ACCW = acc_width(BITS, CBITS, TAPS);
    // Keep at least one index bit so TAPS=1 still elaborates.
    localparam int IDXW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TAPS - 1);

    fsm_state_t             state;
    logic [IDXW-1:0]        idx;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] acc_next;
    logic                   busy_q;
    logic                   valid_q;
    logic signed [ACCW-1:0] y_q;

    logic signed [BITS-1:0]  tap_snap  [TAPS];
    logic signed [CBITS-1:0] coef_snap [TAPS];

    mac_unit #(
        .BITS  (BITS),
        .CBITS (CBITS),
        .ACCW  (ACCW)
    ) u_mac (
        .i_tap  (tap_snap[idx]),
        .i_coef (coef_snap[idx]),
        .i_acc  (acc),
        .o_acc  (acc_next)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state   <= IDLE;
            idx     <= '0;
            acc     <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            y_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (bus.i_start) begin
                        for (int k = 0; k < TAPS; k++) begin
                            tap_snap[k]  <= bus.i_taps[k*BITS +: BITS];
                            coef_snap[k] <= bus.i_coef[k*CBITS +: CBITS];
                        end
                        acc    <= '0;
                        idx    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (idx == LAST_IDX) begin
                        // Final product goes straight to the output; acc is
                        // cleared again by the next accepted start.
                        y_q     <= acc_next;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        idx     <= '0;
                        state   <= IDLE;
                    end else begin
                        acc <= acc_next;
                        idx <= idx + IDXW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_busy    = busy_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_y       = y_q;
    assign bus.dbg_state = state;

endmodule
